// File: rtl/cpu_io_pkg.sv
// rtl/cpu_io_pkg.sv - shared widths and port FSM encoding for the CPU I/O ports
package cpu_io_pkg;

    localparam int DATA_W        = 32;
    localparam int IN_PORT_DEPTH = 4;

    typedef enum logic {
        P_IDLE = 1'b0,
        P_HELD = 1'b1
    } port_state_t;

endpackage

// File: rtl/in_port_fifo.sv
// rtl/in_port_fifo.sv - in-port word storage with explicit occupancy count
module in_port_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic [PTR_W:0]    count,
    output logic              full,
    output logic              empty
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage is intentionally not reset; count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/in_port_buffer.sv
// rtl/in_port_buffer.sv - CPU input port: device handshake, FIFO, one-pop-per-strobe bus read
module in_port_buffer #(
    parameter int DATA_W = cpu_io_pkg::DATA_W,
    parameter int DEPTH  = cpu_io_pkg::IN_PORT_DEPTH,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic [DATA_W-1:0] ext_data,
    input  logic              ext_valid,
    output logic              ext_ready,
    input  logic              InPortout,
    output logic [DATA_W-1:0] BusMuxIn_InPort,
    output logic              in_avail,
    output logic [PTR_W:0]    in_count,
    output logic              underrun,
    input  logic              clr_status
);

    import cpu_io_pkg::*;

    port_state_t       state;
    port_state_t       state_nxt;
    logic              pop_evt;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;
    logic              full;
    logic              empty;

    in_port_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_fifo (
        .clk     (Clock),
        .rst     (Clear),
        .push    (push),
        .wr_data (ext_data),
        .pop     (pop),
        .rd_data (head),
        .count   (in_count),
        .full    (full),
        .empty   (empty)
    );

    assign ext_ready       = !Clear && !full;
    assign push            = ext_valid && ext_ready;
    assign pop             = pop_evt && !empty;
    assign in_avail        = !empty;
    assign BusMuxIn_InPort = empty ? '0 : head;

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state <= P_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // P_HELD plays the role of the delayed InPortout sample.
    always_comb begin
        state_nxt = state;
        pop_evt   = 1'b0;
        case (state)
            P_IDLE: begin
                if (InPortout) begin
                    pop_evt   = 1'b1;
                    state_nxt = P_HELD;
                end
            end
            P_HELD: begin
                if (!InPortout) begin
                    state_nxt = P_IDLE;
                end
            end
            default: state_nxt = P_IDLE;
        endcase
    end

    // A new underrun takes priority over clr_status so no event is lost.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            underrun <= 1'b0;
        end else if (pop_evt && empty) begin
            underrun <= 1'b1;
        end else if (clr_status) begin
            underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_in_port_buffer.sv
// tb/tb_in_port_buffer.sv - directed and randomized checks of in_port_buffer against a queue model
module tb_in_port_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          Clock = 1'b0;
    logic          Clear;
    logic [DW-1:0] ext_data;
    logic          ext_valid;
    logic          ext_ready;
    logic          InPortout;
    logic [DW-1:0] BusMuxIn_InPort;
    logic          in_avail;
    logic [2:0]    in_count;
    logic          underrun;
    logic          clr_status;

    in_port_buffer dut (
        .Clock           (Clock),
        .Clear           (Clear),
        .ext_data        (ext_data),
        .ext_valid       (ext_valid),
        .ext_ready       (ext_ready),
        .InPortout       (InPortout),
        .BusMuxIn_InPort (BusMuxIn_InPort),
        .in_avail        (in_avail),
        .in_count        (in_count),
        .underrun        (underrun),
        .clr_status      (clr_status)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] q[$];
    logic          m_held  = 1'b0;
    logic          m_under = 1'b0;

    logic [DW-1:0] o_bus;
    logic          o_ready;
    logic          o_avail;
    logic          o_under;
    logic [2:0]    o_count;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: apply inputs, compare outputs to the model, then advance the model at the edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic p,
                        input logic cs, input logic cl);
        logic pop_evt;
        logic ready;
        ext_valid  = v;
        ext_data   = d;
        InPortout  = p;
        clr_status = cs;
        Clear      = cl;
        #1;
        o_bus   = BusMuxIn_InPort;
        o_ready = ext_ready;
        o_avail = in_avail;
        o_under = underrun;
        o_count = in_count;
        ready   = !cl && (q.size() != DEPTH);
        check("ext_ready", {31'b0, o_ready}, {31'b0, ready});
        check("bus", o_bus, (q.size() != 0) ? q[0] : '0);
        check("in_count", {29'b0, o_count}, DW'(q.size()));
        check("in_avail", {31'b0, o_avail}, {31'b0, q.size() != 0});
        check("underrun", {31'b0, o_under}, {31'b0, m_under});
        @(posedge Clock);
        if (cl) begin
            q.delete();
            m_held  = 1'b0;
            m_under = 1'b0;
        end else begin
            pop_evt = p && !m_held;
            if (pop_evt && q.size() != 0) void'(q.pop_front());
            if (v && ready) q.push_back(d);
            if (pop_evt && !ready && q.size() == 0) m_under = 1'b1;
            else if (pop_evt && ready && q.size() == ((v) ? 1 : 0) && !(q.size() == 1 && !v)) m_under = m_under;
            m_held = p;
        end
        @(negedge Clock);
    endtask

    // Underrun rule is kept separate from step's arithmetic for clarity: recompute here.
    logic under_pre;

    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic p,
                       input logic cs, input logic cl);
        logic was_empty;
        logic evt;
        was_empty = (q.size() == 0);
        evt       = p && !m_held;
        under_pre = m_under;
        step(v, d, p, cs, cl);
        if (!cl) begin
            if (evt && was_empty) m_under = 1'b1;
            else if (cs)          m_under = 1'b0;
            else                  m_under = under_pre;
        end
    endtask

    task automatic pulse_read(input string tag, input logic [DW-1:0] exp);
        cyc(0, '0, 1, 0, 0);
        check(tag, o_bus, exp);
        cyc(0, '0, 0, 0, 0);
    endtask

    initial begin
        Clear = 1'b1; ext_valid = 1'b0; ext_data = '0; InPortout = 1'b0; clr_status = 1'b0;
        @(negedge Clock);

        cyc(1, 32'hDEAD0000, 0, 0, 1);
        cyc(1, 32'hDEAD0000, 0, 0, 1);
        cyc(0, '0, 0, 0, 0);
        check("reset_count", {29'b0, o_count}, 32'd0);
        check("reset_ready", {31'b0, o_ready}, 32'd1);
        check("reset_bus", o_bus, 32'd0);

        cyc(1, 32'h00000063, 0, 0, 0);
        pulse_read("single_bus", 32'h00000063);
        check("single_count", {29'b0, o_count}, 32'd0);
        check("single_avail", {31'b0, o_avail}, 32'd0);

        cyc(1, 32'hA1, 0, 0, 0);
        cyc(1, 32'hB2, 0, 0, 0);
        cyc(0, '0, 1, 0, 0);
        check("held_bus", o_bus, 32'hA1);
        cyc(0, '0, 1, 0, 0);
        cyc(0, '0, 1, 0, 0);
        cyc(0, '0, 0, 0, 0);
        check("held_count", {29'b0, o_count}, 32'd1);
        pulse_read("held_second", 32'hB2);

        for (int i = 1; i <= 4; i++) cyc(1, DW'(i), 0, 0, 0);
        cyc(1, 32'd5, 0, 0, 0);
        check("full_ready", {31'b0, o_ready}, 32'd0);
        check("full_count", {29'b0, o_count}, 32'd4);
        pulse_read("wrap_pop1", 32'd1);
        pulse_read("wrap_pop2", 32'd2);
        cyc(1, 32'd5, 0, 0, 0);
        cyc(1, 32'd6, 0, 0, 0);
        for (int i = 3; i <= 6; i++) pulse_read("wrap_order", DW'(i));
        check("wrap_empty", {29'b0, o_count}, 32'd0);

        cyc(0, '0, 1, 0, 0);
        check("under_bus", o_bus, 32'd0);
        cyc(0, '0, 0, 0, 0);
        check("under_set", {31'b0, o_under}, 32'd1);
        cyc(0, '0, 0, 1, 0);
        cyc(0, '0, 0, 0, 0);
        check("under_clr", {31'b0, o_under}, 32'd0);
        cyc(0, '0, 1, 1, 0);
        cyc(0, '0, 0, 0, 0);
        check("under_set_wins", {31'b0, o_under}, 32'd1);
        cyc(0, '0, 0, 1, 0);

        cyc(1, 32'd7, 0, 0, 0);
        cyc(1, 32'd8, 0, 0, 0);
        cyc(1, 32'd9, 1, 0, 0);
        check("conc_bus", o_bus, 32'd7);
        cyc(0, '0, 0, 0, 0);
        check("conc_count", {29'b0, o_count}, 32'd2);
        pulse_read("conc_pop8", 32'd8);
        pulse_read("conc_pop9", 32'd9);

        cyc(1, 32'h55, 1, 0, 0);
        cyc(0, '0, 0, 0, 0);
        check("empty_push_pop", {29'b0, o_count}, 32'd1);
        check("empty_push_under", {31'b0, o_under}, 32'd1);

        cyc(0, '0, 1, 0, 0);
        cyc(0, '0, 1, 0, 1);
        cyc(0, '0, 1, 0, 0);
        cyc(0, '0, 0, 0, 0);
        check("clear_new_edge", {31'b0, o_under}, 32'd1);

        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) == 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
